// File: rtl/mul_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_pkg
//  Description : Types and constants shared by the multiplier, the divider
//                and the HI/LO register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_div_pkg;

    // Operand width used by the CPU's MUL/DIV path.
    localparam int c_default_width = 32;

    // The LO half always starts at bit 0 of the packed {HI, LO} result.
    localparam int c_lo_lsb = 0;

    // Iterative controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions of the HI and LO halves in a 2*w-bit {HI, LO} result.
    function automatic int hi_msb(input int w);
        return 2 * w - 1;
    endfunction

    function automatic int hi_lsb(input int w);
        return w;
    endfunction

    function automatic int lo_msb(input int w);
        return w - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
//  Module      : booth_step
//  Description : One radix-2 Booth iteration: add/subtract the multiplicand
//                according to {Q[0], q_m1}, then arithmetic right shift of
//                {A, Q, q_m1} by one bit. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH:0]   i_m,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q_m1,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q_m1
);

    logic [WIDTH:0] w_sum;

    // Booth recoding: 01 adds M, 10 subtracts M, 00/11 keep A.
    always_comb begin
        w_sum = i_a;
        case ({i_q[0], i_q_m1})
            2'b01:   w_sum = i_a + i_m;
            2'b10:   w_sum = i_a - i_m;
            default: w_sum = i_a;
        endcase
    end

    // Arithmetic shift: A's sign bit is replicated, A's LSB falls into Q.
    assign o_a    = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q    = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_q_m1 = i_q[0];

endmodule
`default_nettype wire

// File: rtl/booth_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : booth_multiplier
//  Description : Sequential radix-2 Booth signed multiplier. One Booth step
//                per clock for WIDTH cycles; product presented as {HI, LO}.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_multiplier
    import mul_div_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Z
);

    localparam int c_cnt_w  = $clog2(WIDTH + 1);
    localparam int c_hi_msb = hi_msb(WIDTH);
    localparam int c_hi_lsb = hi_lsb(WIDTH);
    localparam int c_lo_msb = lo_msb(WIDTH);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load;
    logic               w_last_step;

    logic [WIDTH:0]     r_m;
    logic [WIDTH:0]     r_a;
    logic [WIDTH-1:0]   r_q;
    logic               r_qm1;
    logic [c_cnt_w-1:0] r_count;
    logic [2*WIDTH-1:0] r_z;

    logic [WIDTH:0]     w_a_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic               w_qm1_nx;

    // The step taken while count is 1 is the final one.
    assign w_last_step = (r_count == c_cnt_w'(1));

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a    (r_a),
        .i_m    (r_m),
        .i_q    (r_q),
        .i_q_m1 (r_qm1),
        .o_a    (w_a_nx),
        .o_q    (w_q_nx),
        .o_q_m1 (w_qm1_nx)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and operand-load decision; start only counts outside RUN.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                    w_load       = 1'b1;
                end
            end
            RUN: begin
                if (w_last_step) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_next_state = RUN;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: load operands on acceptance, iterate in RUN, capture Z on
    // the final step so it is valid exactly in the DONE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
            r_z     <= '0;
        end else if (w_load) begin
            r_m     <= {Multiplicand[WIDTH-1], Multiplicand};
            r_a     <= '0;
            r_q     <= Multiplier;
            r_qm1   <= 1'b0;
            r_count <= c_cnt_w'(WIDTH);
        end else if (r_state == RUN) begin
            r_a     <= w_a_nx;
            r_q     <= w_q_nx;
            r_qm1   <= w_qm1_nx;
            r_count <= r_count - c_cnt_w'(1);
            if (w_last_step) begin
                r_z[c_hi_msb:c_hi_lsb] <= w_a_nx[WIDTH-1:0];
                r_z[c_lo_msb:c_lo_lsb] <= w_q_nx;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign Z    = r_z;

endmodule
`default_nettype wire
